ml_maxlog_llr_engine: RTL and testbench

// Parametrised max-log ML soft demapper for MIMO detection. Per accepted trigger it sweeps all
// 2^NBITS hypotheses, NPAR per cycle, tracking per-bit running minimum metrics M0/M1.
// It emits true saturated, scaled LLRs (LLR = M1 - M0) plus hard bits through an output FIFO

---
 rtl/ml_maxlog_llr_engine.sv | 158 +++++++++++++++
 tb/tb_ml_maxlog_llr_engine.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ml_maxlog_llr_engine.sv
// Max-log ML soft demapper: sweeps all 2^NBITS hypotheses NPAR per cycle, keeps per-bit minimum
// metrics, then pushes saturated, scaled LLRs and hard bits into a ready/valid output FIFO.
module ml_maxlog_llr_engine #(
    parameter int NBITS     = 8,
    parameter int NPAR      = 4,
    parameter int MW        = 10,
    parameter int LLRW      = 8,
    parameter int BUF_DEPTH = 32
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_trig,
    input  logic [2:0]             i_llr_shift,
    output logic                   o_ready,
    output logic [NBITS-1:0]       o_hyp_base,
    input  logic [NPAR*MW-1:0]     i_metric,
    output logic                   o_vec_done,
    output logic                   o_rd_vld,
    input  logic                   i_rd_rdy,
    output logic signed [LLRW-1:0] o_llr,
    output logic                   o_hard_bit
);
    localparam int S   = (2 ** NBITS) / NPAR;
    localparam int LGP = $clog2(NPAR);
    localparam int CW  = (S > 1) ? $clog2(S) : 1;
    localparam int AW  = $clog2(BUF_DEPTH);
    localparam int PW  = AW + 1;
    localparam int EW  = LLRW + 1;
    localparam logic signed [MW:0] LLR_MAX = (MW + 1)'(2 ** (LLRW - 1) - 1);

    typedef enum logic [1:0] {IDLE, SWEEP, WRITE} state_t;

    state_t                 state_q;
    logic [CW-1:0]          step_q;
    logic [2:0]             shift_q;
    logic                   vec_done_q;
    logic [MW-1:0]          m0_q [NBITS];
    logic [MW-1:0]          m1_q [NBITS];
    logic [MW-1:0]          m0_d [NBITS];
    logic [MW-1:0]          m1_d [NBITS];
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q, count;
    logic [EW-1:0]          mem_q [BUF_DEPTH];
    logic                   empty, full, pop;
    logic signed [LLRW-1:0] llr_v [NBITS];
    logic [NBITS-1:0]       hard_v;

    // Symmetric saturation: the most-negative code is never produced.
    function automatic logic signed [LLRW-1:0] sat_llr(input logic [MW-1:0] m1,
                                                        input logic [MW-1:0] m0,
                                                        input logic [2:0]    sh);
        logic signed [MW:0] d;
        d = $signed({1'b0, m1}) - $signed({1'b0, m0});
        d = d >>> sh;
        if (d > LLR_MAX)
            d = LLR_MAX;
        else if (d < -LLR_MAX)
            d = -LLR_MAX;
        return d[LLRW-1:0];
    endfunction

    assign o_hyp_base = NBITS'(step_q) << LGP;

    always_comb begin
        logic [NBITS-1:0] h;
        logic [MW-1:0]    mv;
        h  = '0;
        mv = '0;
        for (int b = 0; b < NBITS; b++) begin
            m0_d[b] = m0_q[b];
            m1_d[b] = m1_q[b];
        end
        for (int k = 0; k < NPAR; k++) begin
            h  = o_hyp_base + NBITS'(k);
            mv = i_metric[k*MW +: MW];
            for (int b = 0; b < NBITS; b++) begin
                if (h[b]) begin
                    if (mv < m1_d[b]) m1_d[b] = mv;
                end else begin
                    if (mv < m0_d[b]) m0_d[b] = mv;
                end
            end
        end
    end

    always_comb begin
        for (int b = 0; b < NBITS; b++) begin
            llr_v[b]  = sat_llr(m1_q[b], m0_q[b], shift_q);
            hard_v[b] = (m1_q[b] < m0_q[b]);
        end
    end

    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop   = !empty && i_rd_rdy;

    assign o_ready    = (state_q == IDLE) && !full && (count <= PW'(BUF_DEPTH - NBITS));
    assign o_rd_vld   = !empty;
    assign o_vec_done = vec_done_q;
    assign o_llr      = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]][LLRW-1:0];
    assign o_hard_bit = empty ? 1'b0 : mem_q[rd_ptr_q[AW-1:0]][LLRW];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            step_q     <= '0;
            shift_q    <= '0;
            vec_done_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int b = 0; b < NBITS; b++) begin
                m0_q[b] <= '1;
                m1_q[b] <= '1;
            end
        end else begin
            rd_ptr_q <= rd_ptr_q + PW'(pop);
            case (state_q)
                IDLE: begin
                    if (i_trig && o_ready) begin
                        state_q <= SWEEP;
                        step_q  <= '0;
                        shift_q <= i_llr_shift;
                        for (int b = 0; b < NBITS; b++) begin
                            m0_q[b] <= '1;
                            m1_q[b] <= '1;
                        end
                    end
                end
                SWEEP: begin
                    for (int b = 0; b < NBITS; b++) begin
                        m0_q[b] <= m0_d[b];
                        m1_q[b] <= m1_d[b];
                    end
                    step_q <= step_q + CW'(1);
                    if (step_q == CW'(S - 1)) begin
                        state_q    <= WRITE;
                        vec_done_q <= 1'b1;
                    end
                end
                WRITE: begin
                    wr_ptr_q   <= wr_ptr_q + PW'(NBITS);
                    vec_done_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // All NBITS entries land in one cycle; the index wraps modulo BUF_DEPTH.
    always_ff @(posedge i_clk) begin
        if (state_q == WRITE) begin
            for (int b = 0; b < NBITS; b++)
                mem_q[wr_ptr_q[AW-1:0] + AW'(b)] <= {hard_v[b], llr_v[b]};
        end
    end

endmodule

// File: tb/tb_ml_maxlog_llr_engine.sv
// Scoreboard bench for ml_maxlog_llr_engine: directed metric patterns with hand-derived LLRs,
// expected entries queued at trigger time and checked by a monitor on every FIFO pop.
module tb_ml_maxlog_llr_engine;
    localparam int NBITS     = 8;
    localparam int NPAR      = 4;
    localparam int MW        = 10;
    localparam int LLRW      = 8;
    localparam int BUF_DEPTH = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   trig;
    logic [2:0]             sh;
    logic                   ready;
    logic [NBITS-1:0]       hyp;
    logic [NPAR*MW-1:0]     metric;
    logic                   vdone;
    logic                   rvld;
    logic                   rrdy;
    logic signed [LLRW-1:0] llr;
    logic                   hard;

    int         n_chk   = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         pop_cnt = 0;
    int         mode    = 2;
    logic [7:0] key     = 8'h00;
    logic [8:0] exp_q [$];
    logic [8:0] mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ml_maxlog_llr_engine #(
        .NBITS(NBITS), .NPAR(NPAR), .MW(MW), .LLRW(LLRW), .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_trig(trig), .i_llr_shift(sh), .o_ready(ready),
        .o_hyp_base(hyp), .i_metric(metric), .o_vec_done(vdone), .o_rd_vld(rvld),
        .i_rd_rdy(rrdy), .o_llr(llr), .o_hard_bit(hard)
    );

    // Mode 0: 4*popcount(h^key); mode 1: 0 at h=0 else 1023; mode 2: constant 100.
    function automatic logic [MW-1:0] met_of(input logic [7:0] h, input int md, input logic [7:0] k);
        case (md)
            0:       return MW'(4 * $countones(h ^ k));
            1:       return (h == 8'd0) ? MW'(0) : MW'(1023);
            default: return MW'(100);
        endcase
    endfunction

    always_comb begin
        metric = '0;
        for (int k = 0; k < NPAR; k++)
            metric[k*MW +: MW] = met_of(hyp + 8'(k), mode, key);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // Waits for o_ready, triggers one vector and optionally queues its 8 expected entries.
    task automatic start_vec(input int md, input logic [7:0] k, input logic [2:0] s,
                             input int satv, input bit push, output int t_acc);
        int               w;
        logic signed [7:0] v;
        logic             hb;
        w = 0;
        while (!ready && w < 400) begin
            tick();
            w++;
        end
        chk("ready_before_trig", int'(ready), 1);
        mode = md;
        key  = k;
        sh   = s;
        trig = 1'b1;
        tick();
        trig  = 1'b0;
        t_acc = cyc;
        if (push) begin
            for (int b = 0; b < NBITS; b++) begin
                case (md)
                    0:       begin hb = k[b]; v = k[b] ? -8'sd4 : 8'sd4; end
                    1:       begin hb = 1'b0; v = 8'(satv); end
                    default: begin hb = 1'b0; v = 8'sd0; end
                endcase
                exp_q.push_back({hb, v});
            end
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (exp_q.size() > 0 && w < 600) begin
            tick();
            w++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        tick();
        tick();
        chk("fifo_empty_after_drain", int'(rvld), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int w;
        int seen;
        int base;
        rst  = 1'b1;
        trig = 1'b0;
        sh   = 3'd0;
        rrdy = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (!rst && rvld && rrdy) begin
                    pop_cnt++;
                    n_chk++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL pop_entry: got llr=%0d hard=%0d, required no entry", llr, hard);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if ({hard, llr} !== mon_e) begin
                            n_fail++;
                            $display("FAIL pop_entry: got llr=%0d hard=%0d, required llr=%0d hard=%0d",
                                     llr, hard, $signed(mon_e[7:0]), mon_e[8]);
                        end
                    end
                end
            end
        join_none

        // T1: reset, then an asynchronous reset pulse in idle
        repeat (3) tick();
        rst = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("rst_rd_vld", int'(rvld), 0);
        chk("rst_llr", int'(llr), 0);
        chk("rst_hard", int'(hard), 0);
        chk("rst_ready", int'(ready), 1);
        chk("rst_hyp_base", int'(hyp), 0);
        rst = 1'b0;
        tick();

        // T2: popcount metric around 0xA5, latency and hold under i_rd_rdy=0
        start_vec(0, 8'hA5, 3'd0, 0, 1'b1, t);
        w = 0;
        while (!vdone && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("vec_done_time", cyc + 1, t + 65);
        chk("rd_vld_before_write", int'(rvld), 0);
        @(negedge clk);
        chk("vec_done_one_cycle", int'(vdone), 0);
        chk("rd_vld_rise_time", int'(rvld), 1);
        chk("head_llr", int'(llr), -4);
        @(negedge clk);
        chk("head_llr_held", int'(llr), -4);
        chk("head_hard_held", int'(hard), 1);
        tick();
        rrdy = 1'b1;
        drain();

        // T3: saturation with shifts 0, 3, 4
        start_vec(1, 8'h00, 3'd0, 127, 1'b1, t);
        start_vec(1, 8'h00, 3'd3, 127, 1'b1, t);
        start_vec(1, 8'h00, 3'd4, 63, 1'b1, t);
        drain();

        // T4: all metrics equal
        start_vec(2, 8'h00, 3'd0, 0, 1'b1, t);
        drain();

        // T5: back-pressure fills the FIFO with four vectors; a fifth trigger is ignored
        tick();
        rrdy = 1'b0;
        start_vec(0, 8'hA5, 3'd0, 0, 1'b1, t);
        start_vec(0, 8'h3C, 3'd0, 0, 1'b1, t);
        start_vec(0, 8'h0F, 3'd0, 0, 1'b1, t);
        start_vec(0, 8'hF0, 3'd0, 0, 1'b1, t);
        w = 0;
        while (!vdone && w < 200) begin
            tick();
            w++;
        end
        tick();
        tick();
        chk("ready_low_when_full", int'(ready), 0);
        mode = 0;
        key  = 8'h55;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            if (vdone || hyp != 0) seen = 1;
            tick();
        end
        chk("fifth_trigger_ignored", seen, 0);
        base = pop_cnt;
        rrdy = 1'b1;
        w = 0;
        while (!ready && w < 100) begin
            tick();
            w++;
        end
        chk("ready_after_8_pops", int'((pop_cnt - base) >= 8), 1);
        drain();
        chk("pops_total_full_fifo", pop_cnt - base, 32);

        // T6: reset at sweep step 30 aborts the vector; next vector is clean
        start_vec(0, 8'hA5, 3'd0, 0, 1'b0, t);
        w = 0;
        while (hyp != 8'd120 && w < 200) begin
            tick();
            w++;
        end
        chk("reached_step_30", int'(hyp), 120);
        #2 rst = 1'b1;
        #1;
        chk("abort_rd_vld", int'(rvld), 0);
        chk("abort_ready", int'(ready), 1);
        chk("abort_hyp_base", int'(hyp), 0);
        rst = 1'b0;
        tick();
        repeat (70) tick();
        chk("abort_no_entries", int'(rvld), 0);
        start_vec(0, 8'hA5, 3'd0, 0, 1'b1, t);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
